vector_pixel_writer: RTL and testbench
======================================

Name: vector_pixel_writer

Overview:
- Sits directly downstream of the vector line engine. Consumes its per-pixel stream (18-bit pixel address plus write strobe) and commits each pixel to the packed frame buffer.
- Frame buffer format: 4 bpp palette index, 8 pixels per 32-bit word, 640x400 display.
- Each pixel is applied with a read-modify-write on the memory port. Consecutive pixels that fall in the same word are coalesced into a single read/write pair.
- A small FIFO absorbs the engine's one-pixel-per-cycle bursts while the RMW is in progress.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, ≥8).
- PIXEL_COUNT, 256000, valid pixel addresses are 0..PIXEL_COUNT-1.
- ALMOST_FULL_MARGIN, 4, almost_full asserts when count ≥ FIFO_DEPTH-ALMOST_FULL_MARGIN.

Ports:
- clock_in  in  1  system clock
- reset_in  in  1  synchronous, active-high reset
- pixel_address_in  in  18  pixel index from line engine
- pixel_valid_in  in  1  push strobe (engine write_enable_out)
- color_in  in  4  palette index, sampled with each push
- fifo_almost_full_out  out  1  back-pressure hint to draw controller
- overflow_out  out  1  sticky: a push was dropped because FIFO full
- busy_out  out  1  FIFO non-empty or RMW in progress
- mem_address_out  out  15  word address (pixel_address>>3)
- mem_read_enable_out  out  1  one-cycle read strobe
- mem_read_data_in  in  32  read data, valid exactly 1 cycle after read strobe
- mem_write_enable_out  out  1  one-cycle write strobe
- mem_write_data_out  out  32  merged word

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0;
  - FIFO emptied;
  - FSM goes to IDLE;
  - any held, unwritten word is discarded (no write);
  - overflow_out is cleared.
- Push rules:
  - A push (pixel_valid_in=1) with address ≥ PIXEL_COUNT is dropped silently. No FIFO entry is created and no memory access occurs.
  - A push while the FIFO is full is dropped and sets overflow_out. This applies even if a pop happens in the same cycle.
  - An in-range push with the FIFO not full stores {address, color}. The entry is visible (not empty) on the next cycle.
- Nibble placement: pixel p occupies word bits [4*p[2:0] +: 4]. All other nibbles must be preserved.
- FSM states:
  - IDLE: if FIFO not empty, pop the head, latch word address, nibble index and color, then go to READ.
  - READ: mem_read_enable_out=1 with mem_address_out = latched word. Go to WAIT.
  - WAIT: capture mem_read_data_in into held_word, merge the latched nibble, go to HOLD.
  - HOLD:
    - If FIFO not empty and head word == held word: pop, merge its nibble, stay in HOLD (one pixel per cycle).
    - Otherwise go to WRITE.
  - WRITE: mem_write_enable_out=1, mem_write_data_out = held_word, mem_address_out = held word address. Go to IDLE.
- Duplicate pixels in the same run: the last one written wins.
- A held word is never kept across an empty FIFO. HOLD with an empty FIFO always writes back.
- Latency: a single isolated pixel pushed in cycle 0 produces the read strobe in cycle 2 and the write strobe in cycle 5.
- Read and write strobes are never asserted in the same cycle. Memory strobes are registered outputs.
- busy_out = (state != IDLE) | ~fifo_empty. It is registered-consistent, so a controller may wait for it to fall before swapping buffers.

Decomposition:
- Shared package frame_buffer_pkg:
  - DISPLAY_WIDTH=640, DISPLAY_HEIGHT=400, PIXEL_COUNT, BITS_PER_PIXEL=4, PIXELS_PER_WORD=8;
  - pixel_address_t (18b), word_address_t (15b), color_t (4b);
  - FSM state enum.
- Sub-module pixel_fifo: synchronous FIFO with count, full, empty and almost_full. Instantiated once.

Test Plan:
- Single push, addr 10 (word 1, nibble 2), color 0xA, memory word 0x12345678:
  - read strobe at addr 1 in cycle 2;
  - write at cycle 5 of 0x12345A78;
  - busy_out falls in cycle 6.
- 8 consecutive pushes, addr 16..23, colors 0..7, prior word 0xFFFFFFFF:
  - exactly one read and one write, to addr 2;
  - data 0x76543210.
- Pushes at addr 7 then 8 on back-to-back cycles:
  - two separate RMW sequences, word 0 nibble 7 and word 1 nibble 0;
  - write to word 0 precedes read of word 1.
- Push addr 256000 and 262143:
  - no FIFO entry, no memory strobes, busy_out stays 0.
- Hold the memory stall-free but push 40 pixels in distinct words on consecutive cycles:
  - fifo_almost_full_out asserts at count 12;
  - overflow_out sets once the FIFO fills and stays set;
  - later accepted pixels are still written correctly.
- Assert reset_in while in HOLD with a merged word pending:
  - no write strobe ever issued for that word;
  - all outputs 0 on the next cycle;
  - a fresh push after reset is processed normally.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared frame buffer definitions: display geometry, pixel/word types, FSM state codes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package frame_buffer_pkg;

  localparam int DISPLAY_WIDTH   = 640;
  localparam int DISPLAY_HEIGHT  = 400;
  localparam int PIXEL_COUNT     = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int BITS_PER_PIXEL  = 4;
  localparam int PIXELS_PER_WORD = 8;

  typedef logic [17:0] pixel_address_t;
  typedef logic [14:0] word_address_t;
  typedef logic [3:0]  color_t;
  typedef logic [2:0]  nibble_index_t;
  typedef logic [31:0] frame_word_t;

  // One queued pixel: where it goes and what palette index it carries.
  typedef struct packed {
    pixel_address_t address;
    color_t         color;
  } pixel_entry_t;

  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_READ  = 3'd1,
    FSM_WAIT  = 3'd2,
    FSM_HOLD  = 3'd3,
    FSM_WRITE = 3'd4
  } fsm_state_t;

  function automatic word_address_t word_of(pixel_address_t address);
    return address[17:3];
  endfunction

  function automatic nibble_index_t nibble_of(pixel_address_t address);
    return address[2:0];
  endfunction

  // Replace one 4-bit pixel inside a packed word, leaving the other seven untouched.
  function automatic frame_word_t merge_nibble(frame_word_t word, nibble_index_t index,
                                               color_t color);
    frame_word_t result;
    result = word;
    result[{index, 2'b00} +: 4] = color;
    return result;
  endfunction

endpackage

// File: rtl/vector_pixel_writer_if.sv
// Pixel stream from the line engine plus the frame buffer memory port.
// Latency: n/a (wiring only).
// Backpressure: none on the wires; the writer exposes an almost-full hint separately.
interface vector_pixel_writer_if;
  import frame_buffer_pkg::*;

  pixel_address_t pixel_address_in;
  logic           pixel_valid_in;
  color_t         color_in;
  word_address_t  mem_address_out;
  logic           mem_read_enable_out;
  frame_word_t    mem_read_data_in;
  logic           mem_write_enable_out;
  frame_word_t    mem_write_data_out;

  // Engine and memory side: produces pixels and read data, observes the memory strobes.
  modport master (
    output pixel_address_in, pixel_valid_in, color_in, mem_read_data_in,
    input  mem_address_out, mem_read_enable_out, mem_write_enable_out, mem_write_data_out
  );

  // Writer side: consumes pixels, drives the read-modify-write traffic.
  modport slave (
    input  pixel_address_in, pixel_valid_in, color_in, mem_read_data_in,
    output mem_address_out, mem_read_enable_out, mem_write_enable_out, mem_write_data_out
  );
endinterface

// File: rtl/vector_pixel_writer_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and almost-full flag.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: pushes while full and pops while empty are ignored.
module pixel_fifo #(
  parameter int DEPTH              = 16,
  parameter int WIDTH              = 22,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(DEPTH - ALMOST_FULL_MARGIN));
  assign do_push     = push & ~full;
  assign do_pop      = pop & ~empty;
  assign pop_data    = storage[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/vector_pixel_writer.sv
// Commits line-engine pixels to the 4bpp packed frame buffer by read-modify-write, coalescing same-word runs.
// Latency: isolated pixel pushed in cycle 0 -> read strobe cycle 2, write strobe cycle 5.
// Backpressure: none upstream; FIFO absorbs bursts, almost_full hints, overflowing pushes are dropped and flagged.
module vector_pixel_writer #(
  parameter int FIFO_DEPTH         = 16,
  parameter int PIXEL_COUNT        = 256000,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  vector_pixel_writer_if.slave   bus,
  output logic                   fifo_almost_full_out,
  output logic                   overflow_out,
  output logic                   busy_out
);
  import frame_buffer_pkg::*;

  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] IDLE  = FSM_IDLE;
  localparam logic [2:0] READ  = FSM_READ;
  localparam logic [2:0] WAIT  = FSM_WAIT;
  localparam logic [2:0] HOLD  = FSM_HOLD;
  localparam logic [2:0] WRITE = FSM_WRITE;

  logic [2:0]         state;
  word_address_t      lat_word;
  nibble_index_t      lat_nibble;
  color_t             lat_color;
  frame_word_t        held_word;

  logic               in_range;
  logic               push_attempt;
  logic               push_dropped;
  pixel_entry_t       entry_in;
  pixel_entry_t       fifo_head;
  logic               fifo_pop;
  logic [COUNT_W-1:0] fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_almost_full;
  logic               head_same_word;

  // Addresses beyond the visible frame never reach the FIFO or the memory.
  assign in_range     = ({1'b0, bus.pixel_address_in} < 19'(PIXEL_COUNT));
  assign push_attempt = bus.pixel_valid_in & in_range;
  // Judged on the registered full flag: a same-cycle pop does not make room.
  assign push_dropped = push_attempt & fifo_full;
  assign entry_in     = {bus.pixel_address_in, bus.color_in};

  pixel_fifo #(
    .DEPTH              (FIFO_DEPTH),
    .WIDTH              ($bits(pixel_entry_t)),
    .ALMOST_FULL_MARGIN (ALMOST_FULL_MARGIN)
  ) u_pixel_fifo (
    .clk         (clock_in),
    .rst         (reset_in),
    .push        (push_attempt),
    .push_data   (entry_in),
    .pop         (fifo_pop),
    .pop_data    (fifo_head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_almost_full)
  );

  assign head_same_word       = (word_of(fifo_head.address) == lat_word);
  assign fifo_almost_full_out = fifo_almost_full;
  assign busy_out             = (state != IDLE) | (fifo_count != '0);

  // Pop to start a new word from IDLE, or to fold a same-word pixel into the held word.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        fifo_pop = 1'b1;
      end else if ((state == HOLD) && head_same_word) begin
        fifo_pop = 1'b1;
      end
    end
  end

  // RMW sequencer; memory strobes are registered, so each is set on entry to its state.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                    <= IDLE;
      lat_word                 <= '0;
      lat_nibble               <= '0;
      lat_color                <= '0;
      held_word                <= '0;
      bus.mem_address_out      <= '0;
      bus.mem_read_enable_out  <= 1'b0;
      bus.mem_write_enable_out <= 1'b0;
      bus.mem_write_data_out   <= '0;
      overflow_out             <= 1'b0;
    end else begin
      bus.mem_read_enable_out  <= 1'b0;
      bus.mem_write_enable_out <= 1'b0;
      if (push_dropped) overflow_out <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            lat_word                <= word_of(fifo_head.address);
            lat_nibble              <= nibble_of(fifo_head.address);
            lat_color               <= fifo_head.color;
            bus.mem_address_out     <= word_of(fifo_head.address);
            bus.mem_read_enable_out <= 1'b1;
            state                   <= READ;
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          held_word <= merge_nibble(bus.mem_read_data_in, lat_nibble, lat_color);
          state     <= HOLD;
        end
        HOLD: begin
          if (!fifo_empty && head_same_word) begin
            held_word <= merge_nibble(held_word, nibble_of(fifo_head.address), fifo_head.color);
          end else begin
            // Never carry a word across an empty FIFO: write it back now.
            bus.mem_address_out      <= lat_word;
            bus.mem_write_data_out   <= held_word;
            bus.mem_write_enable_out <= 1'b1;
            state                    <= WRITE;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vector_pixel_writer.sv
// Self-checking bench for vector_pixel_writer: vector table, directed corner sequences, random bursts.
// Latency: n/a.
// Backpressure: n/a.
module tb_vector_pixel_writer;

  localparam int NWORDS = 32768;
  localparam int PIX_LIMIT = 256000;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;
  logic fifo_almost_full_out;
  logic overflow_out;
  logic busy_out;

  vector_pixel_writer_if bus ();

  vector_pixel_writer dut (
    .clock_in             (clock_in),
    .reset_in             (reset_in),
    .bus                  (bus),
    .fifo_almost_full_out (fifo_almost_full_out),
    .overflow_out         (overflow_out),
    .busy_out             (busy_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [17:0] addr;
    logic [3:0]  color;
    logic [31:0] init;
    logic [31:0] exp_word;
  } vec_t;

  logic [31:0] fb     [NWORDS];
  logic [31:0] ref_fb [NWORDS];
  ev_t rd_q[$];
  ev_t wr_q[$];
  int  cyc = 0;
  int  both_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  logic        rd_pend = 1'b0;
  logic [14:0] rd_pend_addr = '0;

  // Memory model and strobe recorder, sampled 1 time unit after each rising edge.
  always @(posedge clock_in) begin
    #1;
    cyc++;
    if (rd_pend) bus.mem_read_data_in = fb[rd_pend_addr];
    else         bus.mem_read_data_in = 32'h0;
    rd_pend      = bus.mem_read_enable_out;
    rd_pend_addr = bus.mem_address_out;
    if (bus.mem_read_enable_out) rd_q.push_back('{cyc, bus.mem_address_out, 32'h0});
    if (bus.mem_write_enable_out) begin
      wr_q.push_back('{cyc, bus.mem_address_out, bus.mem_write_data_out});
      fb[bus.mem_address_out] = bus.mem_write_data_out;
    end
    if (bus.mem_read_enable_out && bus.mem_write_enable_out) both_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #2;
  endtask

  task automatic drive(input logic [17:0] a, input logic [3:0] c);
    bus.pixel_valid_in   = 1'b1;
    bus.pixel_address_in = a;
    bus.color_in         = c;
  endtask

  task automatic quiet();
    bus.pixel_valid_in   = 1'b0;
    bus.pixel_address_in = '0;
    bus.color_in         = '0;
  endtask

  // Reference frame: each accepted in-range pixel overwrites its 4-bit slot, in push order.
  task automatic apply_ref(input int a, input logic [3:0] c);
    if (a < PIX_LIMIT) ref_fb[a / 8][(a % 8) * 4 +: 4] = c;
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    fb[w]     = v;
    ref_fb[w] = v;
  endtask

  task automatic clear_log();
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!busy_out) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_idle"}, 64'(done), 64'd1);
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int w;
    int t0;
    int fall;
    w = int'(v.addr) / 8;
    set_word(w, v.init);
    clear_log();
    drive(v.addr, v.color);
    apply_ref(int'(v.addr), v.color);
    t0 = cyc;
    step();
    quiet();
    fall = -1;
    for (int k = 0; k < 30; k++) begin
      if (!busy_out) begin
        fall = cyc - t0;
        break;
      end
      step();
    end
    chk({tag, "_busy_fall"}, 64'(fall), 64'd6);
    chk({tag, "_nreads"}, 64'(rd_q.size()), 64'd1);
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'd1);
    if (rd_q.size() == 1 && wr_q.size() == 1) begin
      chk({tag, "_rd_cycle"}, 64'(rd_q[0].cyc - t0), 64'd2);
      chk({tag, "_rd_addr"}, 64'(rd_q[0].addr), 64'(w));
      chk({tag, "_wr_cycle"}, 64'(wr_q[0].cyc - t0), 64'd5);
      chk({tag, "_wr_addr"}, 64'(wr_q[0].addr), 64'(w));
      chk({tag, "_wr_data"}, 64'(wr_q[0].data), 64'(v.exp_word));
    end
  endtask

  vec_t vecs[5];

  initial begin
    int runs;
    int last_w;
    int len;
    int base;
    int a;
    int m;
    int prev_acc;
    int rd_seen;
    int pop_prev;
    int af_first;
    int af_errs;
    int ovf_errs;
    int accepted;
    int diffs;
    bit ovf_m;
    bit done;
    bit busy_seen;
    logic [3:0] c;

    vecs[0] = '{addr: 18'd10,     color: 4'hA, init: 32'h12345678, exp_word: 32'h12345A78};
    vecs[1] = '{addr: 18'd0,      color: 4'h5, init: 32'h00000000, exp_word: 32'h00000005};
    vecs[2] = '{addr: 18'd255999, color: 4'hF, init: 32'h00000000, exp_word: 32'hF0000000};
    vecs[3] = '{addr: 18'd63,     color: 4'h3, init: 32'hFFFFFFFF, exp_word: 32'h3FFFFFFF};
    vecs[4] = '{addr: 18'd33,     color: 4'h0, init: 32'hFFFFFFFF, exp_word: 32'hFFFFFF0F};

    for (int i = 0; i < NWORDS; i++) set_word(i, $urandom);
    quiet();
    reset_in = 1'b1;
    repeat (3) step();
    chk("reset_rd_en", 64'(bus.mem_read_enable_out), 64'd0);
    chk("reset_wr_en", 64'(bus.mem_write_enable_out), 64'd0);
    chk("reset_addr", 64'(bus.mem_address_out), 64'd0);
    chk("reset_wdata", 64'(bus.mem_write_data_out), 64'd0);
    chk("reset_af", 64'(fifo_almost_full_out), 64'd0);
    chk("reset_ovf", 64'(overflow_out), 64'd0);
    chk("reset_busy", 64'(busy_out), 64'd0);
    reset_in = 1'b0;
    step();

    // Isolated single pixels from the vector table.
    for (int i = 0; i < 5; i++) begin
      run_single(vecs[i], $sformatf("single%0d", i));
      repeat (2) step();
    end

    // Eight pixels filling one word coalesce into one RMW.
    set_word(2, 32'hFFFFFFFF);
    clear_log();
    for (int i = 0; i < 8; i++) begin
      drive(18'(16 + i), 4'(i));
      apply_ref(16 + i, 4'(i));
      step();
    end
    quiet();
    wait_idle("burst8");
    chk("burst8_nreads", 64'(rd_q.size()), 64'd1);
    chk("burst8_nwrites", 64'(wr_q.size()), 64'd1);
    if (rd_q.size() == 1 && wr_q.size() == 1) begin
      chk("burst8_rd_addr", 64'(rd_q[0].addr), 64'd2);
      chk("burst8_wr_addr", 64'(wr_q[0].addr), 64'd2);
      chk("burst8_wr_data", 64'(wr_q[0].data), 64'h76543210);
    end

    // Adjacent pixels straddling a word boundary.
    clear_log();
    drive(18'd7, 4'h5);  apply_ref(7, 4'h5);  step();
    drive(18'd8, 4'hC);  apply_ref(8, 4'hC);  step();
    quiet();
    wait_idle("straddle");
    chk("straddle_nreads", 64'(rd_q.size()), 64'd2);
    chk("straddle_nwrites", 64'(wr_q.size()), 64'd2);
    if (rd_q.size() == 2 && wr_q.size() == 2) begin
      chk("straddle_w0_addr", 64'(wr_q[0].addr), 64'd0);
      chk("straddle_w1_addr", 64'(wr_q[1].addr), 64'd1);
      chk("straddle_order", 64'(wr_q[0].cyc < rd_q[1].cyc), 64'd1);
      chk("straddle_w0_data", 64'(wr_q[0].data), 64'(ref_fb[0]));
      chk("straddle_w1_data", 64'(wr_q[1].data), 64'(ref_fb[1]));
    end

    // Out-of-range pixels leave no trace.
    clear_log();
    busy_seen = 1'b0;
    drive(18'd256000, 4'h7); step(); busy_seen |= busy_out;
    drive(18'd262143, 4'h7); step(); busy_seen |= busy_out;
    quiet();
    for (int k = 0; k < 10; k++) begin
      step();
      busy_seen |= busy_out;
    end
    chk("oor_busy", 64'(busy_seen), 64'd0);
    chk("oor_nreads", 64'(rd_q.size()), 64'd0);
    chk("oor_nwrites", 64'(wr_q.size()), 64'd0);

    // Random short bursts: one RMW per run of same-word in-range pixels.
    for (int b = 0; b < 8; b++) begin
      clear_log();
      len = $urandom_range(1, 8);
      base = $urandom_range(0, 31990);
      runs = 0;
      last_w = -1;
      for (int i = 0; i < len; i++) begin
        a = base * 8 + $urandom_range(0, 23);
        if (i == len - 1 && $urandom_range(0, 2) == 0) a = PIX_LIMIT + $urandom_range(0, 6143);
        c = 4'($urandom);
        if (a < PIX_LIMIT) begin
          if (a / 8 != last_w) runs++;
          last_w = a / 8;
        end
        drive(18'(a), c);
        apply_ref(a, c);
        step();
      end
      quiet();
      step();
      wait_idle($sformatf("rand%0d", b));
      chk($sformatf("rand%0d_nreads", b), 64'(rd_q.size()), 64'(runs));
      chk($sformatf("rand%0d_nwrites", b), 64'(wr_q.size()), 64'(runs));
    end

    // Flood with 40 distinct-word pixels; occupancy tracked from observed read strobes.
    clear_log();
    m = 0; prev_acc = 0; rd_seen = 0; af_first = -1; af_errs = 0; ovf_errs = 0;
    accepted = 0; ovf_m = 1'b0; done = 1'b0;
    for (int cc = 0; cc < 700; cc++) begin
      pop_prev = (rd_q.size() > rd_seen) ? 1 : 0;
      rd_seen  = rd_q.size();
      if (cc > 0) m = m + prev_acc - pop_prev;
      if (fifo_almost_full_out !== (m >= 12)) af_errs++;
      if (fifo_almost_full_out === 1'b1 && af_first < 0) af_first = m;
      if (overflow_out !== ovf_m) ovf_errs++;
      if (cc < 40) begin
        a = cc * 8 + (cc % 8);
        c = 4'(cc);
        drive(18'(a), c);
        prev_acc = (m < 16) ? 1 : 0;
        if (m >= 16) ovf_m = 1'b1;
        else begin
          apply_ref(a, c);
          accepted++;
        end
      end else begin
        quiet();
        prev_acc = 0;
        if (cc > 40 && !busy_out) begin
          done = 1'b1;
          break;
        end
      end
      step();
    end
    chk("flood_drained", 64'(done), 64'd1);
    chk("flood_af_tracking", 64'(af_errs), 64'd0);
    chk("flood_af_first_count", 64'(af_first), 64'd12);
    chk("flood_ovf_tracking", 64'(ovf_errs), 64'd0);
    chk("flood_ovf_sticky", 64'(overflow_out), 64'd1);
    chk("flood_nwrites", 64'(wr_q.size()), 64'(accepted));

    // Reset while a merged word is held: it must be discarded.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive(18'(40 + i), 4'(i + 1));
      step();
    end
    quiet();
    step();
    reset_in = 1'b1;
    step();
    chk("hold_rst_rd_en", 64'(bus.mem_read_enable_out), 64'd0);
    chk("hold_rst_wr_en", 64'(bus.mem_write_enable_out), 64'd0);
    chk("hold_rst_addr", 64'(bus.mem_address_out), 64'd0);
    chk("hold_rst_wdata", 64'(bus.mem_write_data_out), 64'd0);
    chk("hold_rst_af", 64'(fifo_almost_full_out), 64'd0);
    chk("hold_rst_ovf", 64'(overflow_out), 64'd0);
    chk("hold_rst_busy", 64'(busy_out), 64'd0);
    reset_in = 1'b0;
    repeat (20) step();
    chk("hold_rst_nwrites", 64'(wr_q.size()), 64'd0);
    chk("hold_rst_nreads", 64'(rd_q.size()), 64'd1);
    clear_log();
    drive(18'd100, 4'h9);
    apply_ref(100, 4'h9);
    step();
    quiet();
    wait_idle("post_rst");
    chk("post_rst_nwrites", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() == 1) begin
      chk("post_rst_addr", 64'(wr_q[0].addr), 64'd12);
      chk("post_rst_data", 64'(wr_q[0].data), 64'(ref_fb[12]));
    end

    // Whole-frame comparison and strobe exclusivity.
    diffs = 0;
    for (int i = 0; i < NWORDS; i++) begin
      if (fb[i] !== ref_fb[i]) begin
        if (diffs == 0) $display("first frame difference at word %0d: got %h expected %h", i, fb[i], ref_fb[i]);
        diffs++;
      end
    end
    chk("frame_diffs", 64'(diffs), 64'd0);
    chk("strobe_overlap", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
